// File: rtl/multisim_client_quasi_static_pull.sv
// rtl/multisim_client_quasi_static_pull.sv - quasi-static channel receiver: FIFO-buffered beats into a held output register (optional stats: MULTISIM_QS_PULL_STATS_EN)

module multisim_client_quasi_static_pull #(
   parameter SERVER_RUNTIME_DIRECTORY = "../output_top",
   parameter int DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  string                          server_name,
   output logic [DATA_WIDTH-1:0]          data,
   output logic                           data_valid,
   output logic                           data_update
`ifdef MULTISIM_QS_PULL_STATS_EN
   ,
   output logic [31:0]                    update_count,
   output logic [$clog2(FIFO_DEPTH):0]    max_fill
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  data_rdy;
   logic                  beat_vld;
   logic [DATA_WIDTH-1:0] beat_data;
   logic [DATA_WIDTH-1:0] head;
   logic                  push;
   logic                  pop;
   logic                  take;

   // Ready looks only at the registered fill level so it never combinationally depends on the drain.
   assign data_rdy = !rst && (count != CW'(FIFO_DEPTH));
   assign push     = data_rdy && beat_vld;
   assign pop      = !rst && (count != '0);
   assign head     = mem[rd_ptr];
   // The first beat after reset is always applied; later ones only when they differ (X/Z included).
   assign take     = pop && (!data_valid || (head !== data));

   multisim_client_pull #(
      .SERVER_RUNTIME_DIRECTORY(SERVER_RUNTIME_DIRECTORY),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_pull (
      .clk(clk),
      .server_name(server_name),
      .data_rdy(data_rdy),
      .data_vld(beat_vld),
      .data(beat_data)
   );

   // Beat storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= beat_data;
      end
   end

   // Pointers and fill level; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Held output register: one pop per cycle, update pulse only when the value is (re)applied.
   always_ff @(posedge clk) begin
      if (rst) begin
         data        <= RESET_VALUE;
         data_valid  <= 1'b0;
         data_update <= 1'b0;
      end else begin
         data_update <= take;
         if (take) data <= head;
         if (pop)  data_valid <= 1'b1;
      end
   end

`ifdef MULTISIM_QS_PULL_STATS_EN
   // Saturating count of applied updates and high-water mark of the buffer fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         update_count <= '0;
         max_fill     <= '0;
      end else begin
         if (take && (update_count != 32'hFFFF_FFFF)) update_count <= update_count + 32'd1;
         if (count > max_fill) max_fill <= count;
      end
   end
`endif

endmodule

// Stand-alone endpoint for builds without a multisim server: never offers a beat.
module multisim_client_pull #(
   parameter SERVER_RUNTIME_DIRECTORY = "../output_top",
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  string                 server_name,
   input  logic                  data_rdy,
   output logic                  data_vld,
   output logic [DATA_WIDTH-1:0] data
);

   logic unused_ok;

   assign data_vld  = 1'b0;
   assign data      = '0;
   assign unused_ok = ^{clk, data_rdy, SERVER_RUNTIME_DIRECTORY, (server_name.len() != 0)};

endmodule

// File: tb/tb_multisim_client_quasi_static_pull.sv
// tb/tb_multisim_client_quasi_static_pull.sv - self-checking bench for multisim_client_quasi_static_pull

module tb_multisim_client_quasi_static_pull;

   localparam int          DW    = 64;
   localparam int          DEPTH = 4;
   localparam logic [63:0] RV    = 64'hA5;

   logic        clk;
   logic        rst;
   string       srv;
   logic [63:0] data;
   logic        data_valid;
   logic        data_update;
`ifdef MULTISIM_QS_PULL_STATS_EN
   logic [31:0] update_count;
   logic [2:0]  max_fill;
`endif

   logic        drv_vld;
   logic [63:0] drv_data;

   int checks;
   int errors;

   // reference model state
   logic [63:0] mq[$];
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_update;
   int          m_uc;
   int          m_mf;
   logic        exp_rdy;
   logic        obs_rdy;
   logic        acc;

   typedef struct {
      logic        r;
      logic        v;
      logic [63:0] b;
      logic        rdy;
      logic [63:0] d;
      logic        dv;
      logic        du;
   } vec_t;

   vec_t vecs[14];

   multisim_client_quasi_static_pull #(
      .SERVER_RUNTIME_DIRECTORY("../output_top"),
      .DATA_WIDTH(DW),
      .RESET_VALUE(RV),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .server_name(srv),
      .data(data),
      .data_valid(data_valid),
      .data_update(data_update)
`ifdef MULTISIM_QS_PULL_STATS_EN
      ,
      .update_count(update_count),
      .max_fill(max_fill)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, sample ready, step the queue-level model across the edge.
   task automatic step(input logic r, input logic v, input logic [63:0] b);
      logic [63:0] hd;
      int          sz;
      @(negedge clk);
      rst      = r;
      drv_vld  = v;
      drv_data = b;
      force dut.beat_vld  = drv_vld;
      force dut.beat_data = drv_data;
      #1;
      exp_rdy = !r && (mq.size() < DEPTH);
      obs_rdy = dut.data_rdy;
      acc     = exp_rdy && v;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_data   = RV;
         m_valid  = 1'b0;
         m_update = 1'b0;
         m_uc     = 0;
         m_mf     = 0;
      end else begin
         sz = mq.size();
         if (sz > m_mf) m_mf = sz;
         if (sz > 0) begin
            hd       = mq.pop_front();
            m_update = !m_valid || (hd != m_data);
            if (m_update) m_uc++;
            m_data   = hd;
            m_valid  = 1'b1;
         end else begin
            m_update = 1'b0;
         end
         if (acc) mq.push_back(b);
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".rdy"}, 64'(obs_rdy), 64'(exp_rdy));
      check({tag, ".data"}, data, m_data);
      check({tag, ".valid"}, 64'(data_valid), 64'(m_valid));
      check({tag, ".update"}, 64'(data_update), 64'(m_update));
`ifdef MULTISIM_QS_PULL_STATS_EN
      check({tag, ".update_count"}, 64'(update_count), 64'(m_uc));
      check({tag, ".max_fill"}, 64'(max_fill), 64'(m_mf));
`endif
   endtask

   initial begin
      logic [63:0] src[$];
      logic [63:0] seen[$];
      int          n;

      checks   = 0;
      errors   = 0;
      srv      = "qs_pull";
      rst      = 1'b1;
      drv_vld  = 1'b0;
      drv_data = '0;
      m_data   = RV;
      m_valid  = 1'b0;
      m_update = 1'b0;
      m_uc     = 0;
      m_mf     = 0;

      // r, v, beat, rdy, data-after, valid-after, update-after
      vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'hA5, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 64'h9,  1'b0, 64'hA5, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 64'h1,  1'b1, 64'hA5, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h1,  1'b1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h1,  1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 64'h5,  1'b1, 64'h1,  1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 64'h5,  1'b1, 64'h5,  1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 64'h7,  1'b1, 64'h5,  1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h7,  1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h7,  1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'hA5, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 64'hA5, 1'b1, 64'hA5, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'hA5, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'hA5, 1'b1, 1'b0};

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].r, vecs[i].v, vecs[i].b);
         check($sformatf("vec%0d.rdy", i), 64'(obs_rdy), 64'(vecs[i].rdy));
         check($sformatf("vec%0d.data", i), data, vecs[i].d);
         check($sformatf("vec%0d.valid", i), 64'(data_valid), 64'(vecs[i].dv));
         check($sformatf("vec%0d.update", i), 64'(data_update), 64'(vecs[i].du));
      end

      // Burst of six distinct beats: each must surface exactly once, in order.
      for (int i = 0; i < 6; i++) src.push_back(64'h10 + 64'(i));
      n = 0;
      while ((src.size() > 0 || mq.size() > 0 || n < 2) && n < 40) begin
         step(1'b0, src.size() > 0, (src.size() > 0) ? src[0] : 64'h0);
         if (acc) void'(src.pop_front());
         if (data_update) seen.push_back(data);
         check_model("burst");
         n++;
      end
      check("burst.bound", 64'(n < 40), 64'(1));
      check("burst.count", 64'(seen.size()), 64'd6);
      for (int i = 0; i < 6 && i < seen.size(); i++)
         check($sformatf("burst.order%0d", i), seen[i], 64'h10 + 64'(i));

      // Reset while a beat is buffered: flushed, next beat treated as the first.
      step(1'b0, 1'b1, 64'h20);
      check_model("mid.push");
      step(1'b1, 1'b1, 64'h21);
      check_model("mid.rst");
      check("mid.rst.data", data, RV);
      step(1'b0, 1'b1, 64'h10 + 64'd5);
      check_model("mid.after");
      step(1'b0, 1'b0, 64'h0);
      check_model("mid.first");
      check("mid.first.update", 64'(data_update), 64'(1));

      // Randomized traffic with a small value set so duplicates are frequent.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 64'($urandom_range(0, 3)));
         check_model("rand");
      end

`ifdef MULTISIM_QS_PULL_STATS_EN
      // Ten distinct beats after reset produce ten updates.
      step(1'b1, 1'b0, 64'h0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 64'h100 + 64'(i));
      step(1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 64'h0);
      check("stats.update_count", 64'(update_count), 64'd10);
      check("stats.max_fill_le", 64'(max_fill <= 3'd4), 64'(1));
      check_model("stats");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
